receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/nextbus_pkg.sv | 18 +
 rtl/bit_sync.sv | 21 ++
 rtl/receiver.sv | 105 ++++++++++
 tb/tb_receiver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nextbus_pkg.sv
// Shared frame definitions for the nextbus serial link (sender and receiver).
// Holds payload width, receiver state encoding and line levels.
package nextbus_pkg;

  localparam int FRAME_DATA_BITS = 40;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_STOP   = 2'd2,
    S_RESYNC = 2'd3
  } rx_state_t;

  localparam logic LVL_IDLE  = 1'b0;
  localparam logic LVL_START = 1'b1;
  localparam logic LVL_STOP  = 1'b0;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single bit; flops clear to 0 on synchronous reset.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receiver.sv
// Serial frame receiver: start bit, LSB-first payload, stop bit, ready/valid output.
// Define RECEIVER_SYNC_EN to pass sin through a 2-flop synchronizer first.
//   state  | meaning
//   IDLE   | line idle, waiting for a start bit
//   DATA   | shifting in payload bits
//   STOP   | checking the stop bit
//   RESYNC | bad stop seen, waiting for the line to drop low
module receiver
  import nextbus_pkg::*;
#(
  parameter int DATA_WIDTH = FRAME_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sin,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  sample;
  rx_state_t             state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  shift_en, cnt_clr, good_frame, bad_stop;

`ifdef RECEIVER_SYNC_EN
  bit_sync u_bit_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sin),
    .q     (sample)
  );
`else
  assign sample = sin;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    good_frame = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample == LVL_START) begin
          state_next = S_DATA;
          cnt_clr    = 1'b1;
        end
      end
      S_DATA: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) state_next = S_STOP;
      end
      S_STOP: begin
        if (sample == LVL_STOP) begin
          good_frame = 1'b1;
          state_next = S_IDLE;
        end else begin
          bad_stop   = 1'b1;
          state_next = S_RESYNC;
        end
      end
      S_RESYNC: begin
        if (sample == LVL_IDLE) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= good_frame && out_valid && !out_ready;
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + CNT_W'(1);
      if (shift_en) shreg <= {sample, shreg[DATA_WIDTH-1:1]};
      // a consume in the same cycle frees the holding register for the new frame
      if (good_frame && (!out_valid || out_ready)) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed scenarios plus random frames against a frame-level model.
module tb_receiver;
  import nextbus_pkg::*;

  localparam int W = FRAME_DATA_BITS;
`ifdef RECEIVER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid, frame_err, overrun;

  receiver #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // stimulus stream, one entry per clock
  bit q_bit[$];
  bit q_rdy[$];
  bit q_rst[$];

  function automatic bit pick(input int mode);
    if (mode == 2) return ($urandom_range(3) != 0);
    return bit'(mode);
  endfunction

  task automatic push(input bit b, input int mode, input bit rs);
    q_bit.push_back(b);
    q_rdy.push_back(pick(mode));
    q_rst.push_back(rs);
  endtask

  task automatic add_idle(input int n, input int mode);
    repeat (n) push(1'b0, mode, 1'b0);
  endtask

  task automatic add_frame(input logic [W-1:0] p, input int mode);
    push(1'b1, mode, 1'b0);
    for (int b = 0; b < W; b++) push(p[b], mode, 1'b0);
  endtask

  function automatic logic [W-1:0] get_beat(input int idx, input logic [W-1:0] q[$]);
    if (idx < q.size()) return q[idx];
    return 'x;
  endfunction

  // model state
  int           n;
  bit           samp[];
  bit           good_at[];
  bit           bad_at[];
  logic [W-1:0] pay[];
  logic [W-1:0] obs_beats[$];
  logic [W-1:0] m_data;
  bit           m_valid, e_err, e_ovr;
  int           s1, s3, s4, s5, s6, s7;
  int           first_valid;
  int           ovr_s3, err_s4, valid_s6;

  initial begin
    // reset and idle
    repeat (3) push(1'b0, 0, 1'b1);
    add_idle(4, 1);
    // single frame
    s1 = q_bit.size();
    add_frame(40'hD999999991, 1);
    add_idle(10, 1);
    // back-to-back frames, one stop cycle
    add_frame(40'hD999999991, 1);
    add_idle(1, 1);
    add_frame(40'h9999999993, 1);
    add_idle(10, 1);
    // consumer stalled across two frames
    s3 = q_bit.size();
    add_idle(2, 0);
    add_frame(40'hD999999991, 0);
    add_idle(3, 0);
    add_frame(40'h9999999993, 0);
    add_idle(5, 0);
    add_idle(3, 1);
    // bad stop, line held high, then a good frame
    s4 = q_bit.size();
    add_frame(40'h5A5A5A5A5A, 1);
    repeat (6) push(1'b1, 1, 1'b0);
    add_idle(3, 1);
    add_frame(40'h0000000001, 1);
    add_idle(5, 1);
    // reset at payload bit 20; upper payload bits zero so the remainder is ignored
    s5 = q_bit.size();
    add_frame(40'h00000D9991, 1);
    q_rst[s5 + 1 + 20] = 1'b1;
    add_idle(5, 1);
    add_frame(40'h9999999993, 1);
    add_idle(5, 1);
    // long idle
    s6 = q_bit.size();
    add_idle(1000, 2);
    s7 = q_bit.size();
    // random traffic
    for (int f = 0; f < 25; f++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      add_idle($urandom_range(0, 3), 2);
      add_frame(r[W-1:0], 2);
      if ($urandom_range(7) == 0) begin
        repeat ($urandom_range(1, 4)) push(1'b1, 2, 1'b0);
        add_idle(1, 2);
      end else begin
        add_idle($urandom_range(1, 2), 2);
      end
    end
    add_idle(60, 1);

    // line as the FSM sees it (synchronizer delay and its reset)
    n = q_bit.size();
    samp = new[n];
    good_at = new[n];
    bad_at = new[n];
    pay = new[n];
    for (int j = 0; j < n; j++) begin
      samp[j] = (j < LAT) ? 1'b0 : q_bit[j - LAT];
      for (int d = 1; d <= LAT; d++)
        if (j - d >= 0 && q_rst[j - d]) samp[j] = 1'b0;
      good_at[j] = 1'b0;
      bad_at[j] = 1'b0;
      pay[j] = '0;
    end

    // frame-level parse of the sampled line
    begin
      int i, k, ab, jj;
      logic [W-1:0] p;
      i = 0;
      while (i < n) begin
        if (q_rst[i] || !samp[i]) begin
          i++;
          continue;
        end
        ab = -1;
        for (k = 1; k <= W + 1 && i + k < n; k++)
          if (q_rst[i + k]) begin
            ab = i + k;
            break;
          end
        if (ab >= 0) begin
          i = ab + 1;
          continue;
        end
        if (i + W + 1 >= n) break;
        p = '0;
        for (int b = 0; b < W; b++) p[b] = samp[i + 1 + b];
        if (!samp[i + W + 1]) begin
          good_at[i + W + 1] = 1'b1;
          pay[i + W + 1] = p;
          i = i + W + 2;
        end else begin
          bad_at[i + W + 1] = 1'b1;
          jj = i + W + 2;
          while (jj < n && samp[jj] && !q_rst[jj]) jj++;
          i = jj + 1;
        end
      end
    end

    m_data = '0;
    m_valid = 1'b0;
    first_valid = -1;
    ovr_s3 = 0;
    err_s4 = 0;
    valid_s6 = 0;
    @(negedge clk);
    for (int j = 0; j < n; j++) begin
      if (out_valid && q_rdy[j] && !q_rst[j]) obs_beats.push_back(out_data);
      sin = q_bit[j];
      out_ready = q_rdy[j];
      rst_n = !q_rst[j];
      @(negedge clk);
      e_err = bad_at[j];
      e_ovr = 1'b0;
      if (q_rst[j]) begin
        m_valid = 1'b0;
        m_data = '0;
      end else if (good_at[j]) begin
        if (!m_valid || q_rdy[j]) begin
          m_data = pay[j];
          m_valid = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (m_valid && q_rdy[j]) begin
        m_valid = 1'b0;
      end
      check("out_valid", W'(out_valid), W'(m_valid));
      check("out_data", out_data, m_data);
      check("frame_err", W'(frame_err), W'(e_err));
      check("overrun", W'(overrun), W'(e_ovr));
      if (out_valid && first_valid < 0 && j > s1) first_valid = j;
      if (j >= s3 && j < s4 && overrun) ovr_s3++;
      if (j >= s4 && j < s5 && frame_err) err_s4++;
      if (j >= s6 && j < s7 && (out_valid || frame_err || overrun)) valid_s6++;
    end

    check("latency", W'(first_valid - s1 + 1), W'(W + 2 + LAT));
    check("beat0", get_beat(0, obs_beats), 40'hD999999991);
    check("beat1", get_beat(1, obs_beats), 40'hD999999991);
    check("beat2", get_beat(2, obs_beats), 40'h9999999993);
    check("beat3_stall", get_beat(3, obs_beats), 40'hD999999991);
    check("overrun_count", W'(ovr_s3), W'(1));
    check("frame_err_count", W'(err_s4), W'(1));
    check("beat4_after_err", get_beat(4, obs_beats), 40'h0000000001);
    check("beat5_after_rst", get_beat(5, obs_beats), 40'h9999999993);
    check("idle_quiet", W'(valid_s6), W'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
